// File: rtl/credit_pkg.sv
// Shared types and default sizing for the credit-based link sender.
package credit_pkg;

  typedef enum logic [1:0] {
    SND_RESET = 2'd0,
    WAIT_RX   = 2'd1,
    ACTIVE    = 2'd2
  } snd_state_e;

  localparam int DEF_WIDTH       = 8;
  localparam int DEF_MAX_CREDITS = 4;

endpackage

// File: rtl/credit_counter.sv
// Credit bookkeeping: inc/dec with saturation, clear, and a sticky overflow flag.
module credit_counter #(
  parameter int MAX_CREDITS = 4,
  parameter int CW          = $clog2(MAX_CREDITS + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          inc,
  input  logic          dec,
  input  logic          clear,
  output logic [CW-1:0] count,
  output logic          overflow
);

  localparam logic [CW-1:0] MAXC = CW'(MAX_CREDITS);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count    <= '0;
      overflow <= 1'b0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && !dec) begin
      if (count == MAXC) overflow <= 1'b1;
      else               count    <= count + 1'b1;
    end else if (dec && !inc) begin
      // dec is only ever asserted with a nonzero count; guard anyway
      if (count != '0) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/credit_sender.sv
// Credit-based link sender: handshake with receiver reset, spend one credit per beat.
module credit_sender
  import credit_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int MAX_CREDITS = DEF_MAX_CREDITS
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [WIDTH-1:0]                 in_data,
  output logic                             push_valid,
  output logic [WIDTH-1:0]                 push_data,
  input  logic                             push_credit,
  output logic                             push_credit_stall,
  input  logic                             credit_stall,
  output logic                             push_sender_in_reset,
  input  logic                             push_receiver_in_reset,
  output logic [$clog2(MAX_CREDITS+1)-1:0] credit_count,
  output logic                             credit_available,
  output logic                             credit_overflow
);

  snd_state_e state, state_nxt;
  logic       fire, credit_inc, link_drop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= SND_RESET;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      SND_RESET: state_nxt = WAIT_RX;
      WAIT_RX:   if (!push_receiver_in_reset) state_nxt = ACTIVE;
      ACTIVE:    if (push_receiver_in_reset)  state_nxt = WAIT_RX;
      default:   state_nxt = SND_RESET;
    endcase
  end

  assign credit_available     = (state == ACTIVE) && (credit_count != '0);
  assign in_ready             = credit_available;
  assign fire                 = in_valid & in_ready;
  assign push_sender_in_reset = (state == SND_RESET);
  assign push_credit_stall    = credit_stall;

  // Receiver dropping into reset while ACTIVE flushes credits and the beat on that edge.
  assign link_drop  = (state == ACTIVE) & push_receiver_in_reset;
  assign credit_inc = push_credit & (state != SND_RESET) & ~push_receiver_in_reset;

  credit_counter #(
    .MAX_CREDITS (MAX_CREDITS)
  ) u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .inc      (credit_inc),
    .dec      (fire),
    .clear    (link_drop),
    .count    (credit_count),
    .overflow (credit_overflow)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      push_valid <= 1'b0;
      push_data  <= '0;
    end else begin
      push_valid <= fire & ~link_drop;
      if (fire & ~link_drop) push_data <= in_data;
    end
  end

endmodule

// File: doc/credit_sender.md
CREDIT_SENDER -- requirements
Module: credit_sender

Interface
REQ-001 SHALL have parameter WIDTH, default 8, payload bits.
REQ-002 SHALL have parameter MAX_CREDITS, default 4, receiver buffer depth (>=1).
REQ-003 SHALL use one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst_n  input  1  async active-low reset.
REQ-006 in_valid  input  1  client offers in_data.
REQ-007 in_ready  output  1  sender accepts in_data this cycle.
REQ-008 in_data  input  WIDTH  client payload.
REQ-009 push_valid  output  1  link data valid, one beat.
REQ-010 push_data  output  WIDTH  link payload.
REQ-011 push_credit  input  1  one credit returned by the receiver this cycle.
REQ-012 push_credit_stall  output  1  asks the receiver to withhold credit returns; equals credit_stall.
REQ-013 credit_stall  input  1  local stall request.
REQ-014 push_sender_in_reset  output  1  sender not ACTIVE-ready (states SND_RESET).
REQ-015 push_receiver_in_reset  input  1  receiver held in reset.
REQ-016 credit_count  output  $clog2(MAX_CREDITS+1)  credits held.
REQ-017 credit_available  output  1  credit_count!=0 and state ACTIVE.
REQ-018 credit_overflow  output  1  sticky: credit returned while count==MAX_CREDITS.

Function
REQ-019 FSM states: SND_RESET, WAIT_RX, ACTIVE; SHALL be SND_RESET during reset.
REQ-020 SND_RESET -> WAIT_RX unconditionally on the first clock after rst_n deasserts.
REQ-021 WAIT_RX -> ACTIVE when push_receiver_in_reset==0; otherwise stays.
REQ-022 ACTIVE -> WAIT_RX when push_receiver_in_reset==1; credit_count cleared to 0 and push_valid forced 0 on that edge.
REQ-023 push_sender_in_reset SHALL be 1 exactly in SND_RESET.
REQ-024 in_ready SHALL equal credit_available (combinational; no dependence on in_valid).
REQ-025 fire = in_valid & in_ready; on fire push_valid<=1, push_data<=in_data (1-cycle latency); else push_valid<=0, push_data holds.
REQ-026 credit_count next = count + (push_credit & state!=SND_RESET & !push_receiver_in_reset) - fire; simultaneous credit and fire leaves count unchanged.
REQ-027 Credits arriving in SND_RESET or while push_receiver_in_reset==1 SHALL be ignored.
REQ-028 Increment at count==MAX_CREDITS without fire SHALL saturate and set credit_overflow until reset.
REQ-029 Count SHALL never underflow: fire requires count>=1.
REQ-030 Back-to-back fires SHALL be allowed every cycle while credits remain.

Reset
REQ-031 rst_n low SHALL immediately set state=SND_RESET, credit_count=0, push_valid=0, push_data=0, credit_overflow=0.
REQ-032 Outputs during reset: in_ready=0, credit_available=0, push_sender_in_reset=1, push_credit_stall=credit_stall.
REQ-033 Reset mid-transfer SHALL drop the in-flight beat; nothing is replayed.

Structure
REQ-034 Package credit_pkg SHALL hold the state enum typedef (snd_state_e) and the default WIDTH/MAX_CREDITS constants.
REQ-035 Credit arithmetic SHALL live in one sub-module credit_counter (inc, dec, clear, saturate, overflow flag).
REQ-036 All flops SHALL be async-reset on negedge rst_n; no latches.

Verification
REQ-037 Reset release with push_receiver_in_reset=0 -> push_sender_in_reset 1 for one cycle after release, ACTIVE on the 2nd edge, credit_count=0, in_ready=0.
REQ-038 4 push_credit pulses then in_valid held high with data 0x11..0x16 -> exactly 0x11..0x14 emitted on consecutive cycles, credit_count 4->0, in_ready=0 afterwards.
REQ-039 count=1, push_credit and fire same cycle -> count stays 1, push_valid=1 next cycle.
REQ-040 count=4, push_credit with no fire -> count stays 4, credit_overflow=1 and stays 1.
REQ-041 ACTIVE, count=3, push_receiver_in_reset pulses high 2 cycles with credits -> count=0, push_valid=0, WAIT_RX then ACTIVE; credits during pulse ignored.
REQ-042 rst_n asserted mid-stream -> push_valid=0 and count=0 asynchronously, push_sender_in_reset=1 before next clock edge.
